// File: rtl/conv_mac_scheduler.sv
// rtl/conv_mac_scheduler.sv - sequencer for a 1-D valid convolution over a single-port x memory and filter ROM
//
// Purpose: loads LENX samples into x memory, then for each output index k
// issues addresses k+j / j (j = 0..LENF-1) to x memory and filter ROM,
// strobes the accumulator and presents the result with a valid/ready handshake.
//
// Ports:
//   clk, reset             single clock, synchronous active-high reset
//   s_valid_x / s_ready_x  sample input handshake (accepted only while loading)
//   x_wr_en, x_addr        x memory write strobe and shared read/write address
//   f_addr                 filter ROM address
//   clr_acc, en_acc        accumulator clear / accumulate strobes
//   m_valid_y / m_ready_y  result handshake
//   out_idx                index k of the result being computed / presented
//   frame_done             one-cycle pulse after the last result of a frame is taken
module conv_mac_scheduler #(
    parameter int LENX  = 8,
    parameter int LENF  = 4,
    parameter int ADDRX = 3,
    parameter int ADDRF = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid_x,
    output logic             s_ready_x,
    output logic             x_wr_en,
    output logic [ADDRX-1:0] x_addr,
    output logic [ADDRF-1:0] f_addr,
    output logic             clr_acc,
    output logic             en_acc,
    output logic             m_valid_y,
    input  logic             m_ready_y,
    output logic [ADDRX-1:0] out_idx,
    output logic             frame_done
);

    typedef enum logic [2:0] {
        S_LOAD,
        S_CLR,
        S_MAC,
        S_DRAIN,
        S_OUT
    } state_t;

    localparam logic [ADDRX-1:0] WC_LAST = ADDRX'(LENX - 1);
    localparam logic [ADDRX-1:0] K_LAST  = ADDRX'(LENX - LENF);
    localparam logic [ADDRF-1:0] J_LAST  = ADDRF'(LENF - 1);

    state_t           r_state;
    state_t           w_next;
    logic [ADDRX-1:0] r_wc;
    logic [ADDRX-1:0] r_k;
    logic [ADDRF-1:0] r_j;
    logic [ADDRX-1:0] r_xa;    // last issued x read address, held through DRAIN/OUT
    logic [ADDRF-1:0] r_fa;    // last issued filter address
    logic             r_en_acc;
    logic             r_frame_done;
    logic [ADDRX-1:0] w_kj;
    logic             w_hs;

    assign w_kj       = r_k + ADDRX'(r_j);
    assign w_hs       = (r_state == S_OUT) && m_ready_y;
    assign out_idx    = r_k;
    assign en_acc     = r_en_acc;
    assign frame_done = r_frame_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        s_ready_x = 1'b0;
        x_wr_en   = 1'b0;
        x_addr    = r_xa;
        f_addr    = r_fa;
        clr_acc   = reset;
        m_valid_y = 1'b0;
        case (r_state)
            S_LOAD: begin
                s_ready_x = 1'b1;
                x_wr_en   = s_valid_x;
                x_addr    = r_wc;
                f_addr    = '0;
                if (s_valid_x && (r_wc == WC_LAST)) begin
                    w_next = S_CLR;
                end
            end
            S_CLR: begin
                // tap 0 is issued here, so a one-tap filter skips MAC entirely
                clr_acc = 1'b1;
                x_addr  = r_k;
                f_addr  = '0;
                w_next  = (LENF == 1) ? S_DRAIN : S_MAC;
            end
            S_MAC: begin
                x_addr = w_kj;
                f_addr = r_j;
                if (r_j == J_LAST) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // waits out the read latency of the last tap
                w_next = S_OUT;
            end
            S_OUT: begin
                m_valid_y = 1'b1;
                if (m_ready_y) begin
                    w_next = (r_k == K_LAST) ? S_LOAD : S_CLR;
                end
            end
            default: begin
                w_next = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wc         <= '0;
            r_k          <= '0;
            r_j          <= '0;
            r_xa         <= '0;
            r_fa         <= '0;
            r_en_acc     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            // memory data for an address issued in CLR/MAC arrives one cycle later
            r_en_acc     <= (r_state == S_CLR) || (r_state == S_MAC);
            r_frame_done <= w_hs && (r_k == K_LAST);
            case (r_state)
                S_LOAD: begin
                    if (s_valid_x) begin
                        r_wc <= (r_wc == WC_LAST) ? '0 : r_wc + 1'b1;
                    end
                end
                S_CLR: begin
                    r_j  <= ADDRF'(1);
                    r_xa <= r_k;
                    r_fa <= '0;
                end
                S_MAC: begin
                    r_j  <= r_j + 1'b1;
                    r_xa <= w_kj;
                    r_fa <= r_j;
                end
                S_OUT: begin
                    if (m_ready_y) begin
                        r_k <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mac_scheduler.sv
// tb/tb_conv_mac_scheduler.sv - directed self-checking bench for conv_mac_scheduler
module tb_conv_mac_scheduler;

    logic clk = 1'b0;
    logic reset;
    logic sv, mr;
    logic sv2, mr2;

    logic       s_ready, x_wr_en, clr_acc, en_acc, m_valid, frame_done;
    logic [2:0] x_addr, out_idx;
    logic [1:0] f_addr;

    logic       a_ready, a_wr, a_clr, a_en, a_valid, a_fd;
    logic [1:0] a_xaddr, a_idx;
    logic [0:0] a_faddr;

    logic       b_ready, b_wr, b_clr, b_en, b_valid, b_fd;
    logic [1:0] b_xaddr, b_idx;
    logic [0:0] b_faddr;

    int total = 0;
    int bad   = 0;
    int sb[$];
    int wq[$];

    always #5 clk = ~clk;

    conv_mac_scheduler #(.LENX(8), .LENF(4), .ADDRX(3), .ADDRF(2)) dut (
        .clk(clk), .reset(reset), .s_valid_x(sv), .s_ready_x(s_ready),
        .x_wr_en(x_wr_en), .x_addr(x_addr), .f_addr(f_addr),
        .clr_acc(clr_acc), .en_acc(en_acc), .m_valid_y(m_valid),
        .m_ready_y(mr), .out_idx(out_idx), .frame_done(frame_done)
    );

    conv_mac_scheduler #(.LENX(3), .LENF(2), .ADDRX(2), .ADDRF(1)) dut_a (
        .clk(clk), .reset(reset), .s_valid_x(sv2), .s_ready_x(a_ready),
        .x_wr_en(a_wr), .x_addr(a_xaddr), .f_addr(a_faddr),
        .clr_acc(a_clr), .en_acc(a_en), .m_valid_y(a_valid),
        .m_ready_y(mr2), .out_idx(a_idx), .frame_done(a_fd)
    );

    conv_mac_scheduler #(.LENX(3), .LENF(1), .ADDRX(2), .ADDRF(1)) dut_b (
        .clk(clk), .reset(reset), .s_valid_x(sv2), .s_ready_x(b_ready),
        .x_wr_en(b_wr), .x_addr(b_xaddr), .f_addr(b_faddr),
        .clr_acc(b_clr), .en_acc(b_en), .m_valid_y(b_valid),
        .m_ready_y(mr2), .out_idx(b_idx), .frame_done(b_fd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #2;
    endtask

    // Eight beats with s_valid_x held; leaves the bench in the first CLR cycle.
    task automatic load_frame();
        for (int i = 0; i < 8; i++) wq.push_back(i);
        for (int i = 0; i < 8; i++) begin
            sv = 1'b1;
            #1;
            chk("load_ready", s_ready, 1);
            chk("load_wr", x_wr_en, 1);
            chk("load_addr", x_addr, wq.pop_front());
            adv();
        end
        sv = 1'b0;
    endtask

    // Runs from the first CLR cycle, m_ready_y held high, until frame_done.
    task automatic run_outputs(input int n);
        int c, last, nv, enc, clrc;
        bit done;
        for (int i = 0; i < n; i++) sb.push_back(i);
        c = 0; last = -1; nv = 0; enc = 0; clrc = 0; done = 0;
        while (!done && c < 200) begin
            if (en_acc) enc++;
            if (clr_acc) clrc++;
            if (m_valid) begin
                if (sb.size() == 0) chk("sb_extra_out", out_idx, 32'hFFFF);
                else chk("out_idx", out_idx, sb.pop_front());
                chk("out_gap", c - ((last < 0) ? 0 : last), (last < 0) ? 5 : 6);
                last = c;
                nv++;
            end
            if (frame_done) begin
                chk("fd_timing", c, last + 1);
                done = 1;
            end else begin
                adv();
                c++;
            end
        end
        chk("fd_seen", done, 1);
        chk("n_outputs", nv, n);
        chk("en_cycles", enc, 4 * n);
        chk("clr_cycles", clrc, n);
    endtask

    task automatic wait_valid(input string tag);
        int c;
        c = 0;
        while (!m_valid && c < 20) begin
            chk({tag, "_noready"}, s_ready, 0);
            chk({tag, "_nowr"}, x_wr_en, 0);
            adv();
            c++;
        end
        chk({tag, "_valid"}, m_valid, 1);
    endtask

    initial begin
        logic [2:0] xa;
        int n1, n2, e1, e2, beats;
        bit d1, d2, pclr;

        reset = 1'b1; sv = 1'b0; mr = 1'b0; sv2 = 1'b0; mr2 = 1'b0;
        adv();
        chk("rst_ready", s_ready, 1);
        chk("rst_wr", x_wr_en, 0);
        chk("rst_xaddr", x_addr, 0);
        chk("rst_faddr", f_addr, 0);
        chk("rst_clr", clr_acc, 1);
        chk("rst_en", en_acc, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_fd", frame_done, 0);
        reset = 1'b0;
        #1;
        chk("load_clr_low", clr_acc, 0);

        // frame 1: straight through
        load_frame();
        mr = 1'b1;
        run_outputs(5);
        mr = 1'b0;
        adv();

        // frame 2: toggling s_valid_x, then stalls and a detailed CLR k=2 walk
        sb.push_back(0); sb.push_back(1); sb.push_back(2);
        beats = 0;
        for (int i = 0; i < 15; i++) begin
            sv = (i % 2 == 0);
            #1;
            chk("tog_ready", s_ready, 1);
            chk("tog_wr", x_wr_en, sv);
            if (sv) begin
                chk("tog_addr", x_addr, beats);
                beats++;
            end
            adv();
        end
        sv = 1'b1;
        #1;
        chk("f2_clr", clr_acc, 1);
        chk("f2_ready_off", s_ready, 0);
        chk("f2_wr_off", x_wr_en, 0);
        wait_valid("k0");
        chk("k0_idx", out_idx, sb.pop_front());
        mr = 1'b1;
        adv();
        mr = 1'b0;
        wait_valid("k1");
        chk("k1_idx", out_idx, sb.pop_front());
        xa = x_addr;
        for (int i = 0; i < 10; i++) begin
            adv();
            chk("stall_valid", m_valid, 1);
            chk("stall_idx", out_idx, 1);
            chk("stall_xaddr", x_addr, xa);
        end
        mr = 1'b1;
        adv();
        mr = 1'b0;
        chk("k2_clr", clr_acc, 1);
        chk("k2_idx", out_idx, 2);
        chk("k2_xaddr", x_addr, 2);
        chk("k2_faddr", f_addr, 0);
        chk("k2_en0", en_acc, 0);
        for (int j = 1; j < 4; j++) begin
            adv();
            chk("k2_mac_x", x_addr, 2 + j);
            chk("k2_mac_f", f_addr, j);
            chk("k2_mac_en", en_acc, 1);
            chk("k2_mac_clr", clr_acc, 0);
            chk("k2_mac_wr", x_wr_en, 0);
        end
        adv();
        chk("drain_x", x_addr, 5);
        chk("drain_f", f_addr, 3);
        chk("drain_en", en_acc, 1);
        chk("drain_valid", m_valid, 0);
        adv();
        chk("k2_out_en", en_acc, 0);
        chk("k2_out_valid", m_valid, 1);
        chk("k2_out_idx", out_idx, sb.pop_front());
        mr = 1'b1;
        adv();
        mr = 1'b0;
        chk("k3_clr", clr_acc, 1);
        chk("k3_idx", out_idx, 3);
        adv();
        adv();
        chk("k3_j2_x", x_addr, 5);
        chk("k3_j2_f", f_addr, 2);
        reset = 1'b1;
        adv();
        chk("mr_ready", s_ready, 1);
        chk("mr_valid", m_valid, 0);
        chk("mr_idx", out_idx, 0);
        chk("mr_fd", frame_done, 0);
        chk("mr_clr", clr_acc, 1);
        reset = 1'b0;
        sb.delete();
        wq.delete();

        // frame 3: complete frame after the abort
        load_frame();
        mr = 1'b1;
        run_outputs(5);
        mr = 1'b0;
        sv = 1'b0;

        // small configurations, run side by side
        sv2 = 1'b1; mr2 = 1'b1;
        n1 = 0; n2 = 0; e1 = 0; e2 = 0; d1 = 0; d2 = 0; pclr = 0;
        for (int c = 0; c < 40; c++) begin
            if (!d2) begin
                if (a_en) e2++;
                if (a_valid) begin
                    chk("a_idx", a_idx, n2);
                    n2++;
                end
                if (a_fd) d2 = 1;
            end
            if (!d1) begin
                if (b_en) e1++;
                if (pclr) begin
                    chk("b_drain_en", b_en, 1);
                    chk("b_drain_valid", b_valid, 0);
                end
                if (b_valid) begin
                    chk("b_idx", b_idx, n1);
                    n1++;
                end
                if (b_fd) d1 = 1;
                pclr = b_clr;
            end
            adv();
        end
        chk("a_done", d2, 1);
        chk("a_outputs", n2, 2);
        chk("a_en_cycles", e2, 4);
        chk("b_done", d1, 1);
        chk("b_outputs", n1, 3);
        chk("b_en_cycles", e1, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_mac_scheduler.md
CONV_MAC_SCHEDULER -- requirements
Module: conv_mac_scheduler

Interface
REQ-001 The parameters SHALL be, one per line (name, default, meaning):
- LENX, 8, input vector length; LENF <= LENX.
- LENF, 4, filter length; LENF >= 1.
- ADDRX, 3, x address width; 2**ADDRX >= LENX.
- ADDRF, 2, filter address width; 2**ADDRF >= LENF.

REQ-002 The ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, the single clock.
- reset, in, 1, synchronous, active-high.
- s_valid_x, in, 1, input sample valid.
- s_ready_x, out, 1, scheduler accepts a sample.
- x_wr_en, out, 1, write strobe to the single-port x memory.
- x_addr, out, ADDRX, x memory address, shared by read and write.
- f_addr, out, ADDRF, filter ROM address.
- clr_acc, out, 1, clear the MAC accumulator.
- en_acc, out, 1, accumulate the current memory outputs.
- m_valid_y, out, 1, accumulator result valid.
- m_ready_y, in, 1, downstream accepts the result.
- out_idx, out, ADDRX, index k of the current output.
- frame_done, out, 1, one-cycle pulse after the last output is accepted.

REQ-003 The block SHALL have one clock and a synchronous active-high reset, named clk and reset.

Function
REQ-004 The FSM SHALL have exactly five states: LOAD, CLR, MAC, DRAIN, OUT.

REQ-005 In LOAD:
- s_ready_x = 1 and x_wr_en = s_valid_x (combinational); x_addr = the write counter wc.
- wc increments on each accepted beat.
- The beat that makes wc reach LENX goes to CLR on the next cycle and sets wc to 0.

REQ-006 While not in LOAD, s_ready_x = 0 and x_wr_en = 0; s_valid_x is ignored.

REQ-007 CLR lasts one cycle:
- Outputs: clr_acc = 1, x_addr = k, f_addr = 0, and the tap counter j is set to 1.
- If LENF = 1, CLR goes to DRAIN; otherwise it goes to MAC.

REQ-008 MAC:
- Each cycle drives x_addr = k+j and f_addr = j, then j increments.
- After issuing j = LENF-1, MAC goes to DRAIN.

REQ-009 DRAIN lasts one cycle and issues no new address; x_addr and f_addr hold their last values.

REQ-010 Memory and ROM reads have 1-cycle latency. en_acc SHALL be 1 exactly in the cycle after each address issue, i.e. for LENF consecutive cycles starting the cycle after CLR. en_acc is 0 at all other times.

REQ-011 OUT:
- m_valid_y = 1, held until the cycle in which m_ready_y = 1 (the handshake).
- If k < LENX-LENF at the handshake: k increments and the FSM goes to CLR.
- If k = LENX-LENF at the handshake: k becomes 0, the FSM goes to LOAD, and frame_done = 1 for the following cycle.

REQ-012 m_valid_y SHALL never deassert without a handshake.

REQ-013 Outputs per frame SHALL be LENX-LENF+1. The cycle count from CLR entry to first m_valid_y SHALL be LENF+1. When m_ready_y is held at 1, consecutive results SHALL be LENF+2 cycles apart.

REQ-014 out_idx SHALL equal k at all times. The address k+j SHALL never exceed LENX-1, and f_addr SHALL never exceed LENF-1.

REQ-015 Boundary cases:
- LENF = LENX: exactly one output per frame.
- m_ready_y asserted before m_valid_y has no effect.
- A new frame's first beat is accepted in the cycle after frame_done.

Reset
REQ-016 On reset, at the next clock edge:
- FSM = LOAD; wc = 0, k = 0, j = 0.
- s_ready_x = 1 (combinational, in LOAD).
- x_wr_en = 0, x_addr = 0, f_addr = 0, clr_acc = 1, en_acc = 0, m_valid_y = 0, out_idx = 0, frame_done = 0.

REQ-017 Reset asserted in any state, including mid-MAC or in OUT with m_valid_y = 1, SHALL abandon the frame. No handshake is completed and no frame_done pulse is produced.

REQ-018 clr_acc SHALL be 1 only in CLR and during reset; it is 0 in LOAD after reset.

Verification
REQ-019 The bench SHALL cover these directed scenarios, all with LENX=8, LENF=4:
- 8 beats with s_valid_x held at 1, then m_ready_y held at 1. Required: x_addr 0..7 with x_wr_en; exactly 5 m_valid_y pulses with out_idx 0..4, 6 cycles apart; frame_done 1 cycle after the 5th.
- CLR for k=2. Required: next cycles show x_addr/f_addr = 3/1, 4/2, 5/3; en_acc high for exactly 4 cycles; clr_acc high for 1 cycle.
- m_ready_y held at 0 for 10 cycles during OUT at k=1. Required: m_valid_y stays 1 and out_idx stays 1; x_addr is unchanged; handshake then proceeds to CLR with k=2.
- s_valid_x toggling 1,0,1,... during LOAD, plus s_valid_x = 1 held during MAC. Required: only LOAD beats are written (8 total); s_ready_x = 0 outside LOAD.
- reset pulsed during MAC at k=3, j=2. Required: the next cycle shows LOAD, s_ready_x = 1, m_valid_y = 0, out_idx = 0, and no frame_done; a full new frame then completes normally.
- Configuration LENX=3, LENF=2. Required: 2 outputs per frame; a LENF=1 build goes CLR to DRAIN with en_acc for one cycle.
